// File: rtl/bnn_pkg.sv
// Shared constants and FSM state type for the BNN nibble-serial weight streamer.
package bnn_pkg;

    localparam int NUM_NEURONS_DEF = 12;
    localparam int NIBBLE_W        = 4;
    localparam int WEIGHT_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LO,
        HI,
        FIN
    } state_t;

endpackage

// File: rtl/bnn_byte_fifo.sv
// Small power-of-two byte FIFO with occupancy count; reset flushes it by clearing pointers.
module bnn_byte_fifo
    import bnn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WEIGHT_W-1:0] push_data,
    input  logic                pop,
    output logic [CNT_W-1:0]    count,
    output logic [WEIGHT_W-1:0] head
);

    logic [WEIGHT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push = push & (count < CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bnn_weight_streamer.sv
// Streams NUM_NEURONS weight bytes to the BNN core as low/high nibble pairs.
// Optional running XOR checksum on csum when WSTREAM_CHECKSUM_EN is defined.
module bnn_weight_streamer
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WEIGHT_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                hold,
    output logic                load_en,
    output logic [NIBBLE_W-1:0] nibble,
    output logic [4:0]          idx,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WEIGHT_W-1:0] csum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ACC_W = $clog2(NUM_NEURONS + 1);
    localparam logic [4:0] LAST_IDX = 5'(NUM_NEURONS - 1);

    state_t              state;
    logic [ACC_W-1:0]    accepted_count;
    logic [CNT_W-1:0]    fifo_count;
    logic [WEIGHT_W-1:0] head;
    logic                push;
    logic                pop;

    assign push = in_valid & in_ready;
    assign pop  = (state == HI) & ~hold;
    assign busy = (state == FETCH) | (state == LO) | (state == HI);

    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH))
                    & (accepted_count < ACC_W'(NUM_NEURONS))
                    & (state != FIN);

    bnn_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (head)
    );

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_en = 1'b0;
        nibble  = '0;
        if (!hold) begin
            case (state)
                LO: begin
                    load_en = 1'b1;
                    nibble  = head[3:0];
                end
                HI: begin
                    load_en = 1'b1;
                    nibble  = head[7:4];
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            accepted_count <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) accepted_count <= accepted_count + 1'b1;
            if (start && state != IDLE) error <= 1'b1;
            // hold freezes sequencing; the FIFO keeps accepting bytes meanwhile.
            if (!hold) begin
                case (state)
                    IDLE:  if (start) state <= (fifo_count != '0) ? LO : FETCH;
                    FETCH: if (fifo_count != '0) state <= LO;
                    LO:    state <= HI;
                    HI: begin
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= (fifo_count > CNT_W'(1) || push) ? LO : FETCH;
                        end
                    end
                    FIN:     state <= FIN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef WSTREAM_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    csum <= '0;
        else if (pop) csum <= csum ^ head;
    end
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed self-checking bench for bnn_weight_streamer (default NUM_NEURONS=12, FIFO_DEPTH=4).
module tb_bnn_weight_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       hold;
    logic       load_en;
    logic [3:0] nibble;
    logic [4:0] idx;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] csum;

    int checks = 0;
    int errors = 0;

`ifdef WSTREAM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    bnn_weight_streamer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .hold     (hold),
        .load_en  (load_en),
        .nibble   (nibble),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .csum     (csum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        check({pfx, "_load_en"},  32'(load_en),  32'd0);
        check({pfx, "_nibble"},   32'(nibble),   32'd0);
        check({pfx, "_idx"},      32'(idx),      32'd0);
        check({pfx, "_busy"},     32'(busy),     32'd0);
        check({pfx, "_done"},     32'(done),     32'd0);
        check({pfx, "_error"},    32'(error),    32'd0);
        check({pfx, "_csum"},     32'(csum),     32'd0);
    endtask

    initial begin
        logic [7:0] exp_csum;
        int nb;
        int le_cnt;
        int le_first;
        int le_last;
        int done_cnt;
        int done_cyc;
        int extra_accept;
        bit cap_checked;

        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        hold     = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        #1;
        check_reset_values("rst");

        // Session 1: preload A0, 41 then start.
        next_cycle();
        in_valid = 1'b1; in_data = 8'hA0;
        next_cycle();
        in_data = 8'h41;
        next_cycle();
        in_valid = 1'b0; start = 1'b1;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        next_cycle();
        start = 1'b0;
        #1;
        check("s1_lo0_le",  32'(load_en), 32'd1);
        check("s1_lo0_nib", 32'(nibble),  32'h0);
        check("s1_lo0_idx", 32'(idx),     32'd0);
        check("s1_busy",    32'(busy),    32'd1);
        next_cycle(); #1;
        check("s1_hi0_le",  32'(load_en), 32'd1);
        check("s1_hi0_nib", 32'(nibble),  32'hA);
        next_cycle(); #1;
        check("s1_lo1_le",  32'(load_en), 32'd1);
        check("s1_lo1_nib", 32'(nibble),  32'h1);
        check("s1_lo1_idx", 32'(idx),     32'd1);
        next_cycle(); #1;
        check("s1_hi1_nib", 32'(nibble),  32'h4);
        next_cycle(); #1;
        check("s1_fetch_le",   32'(load_en), 32'd0);
        check("s1_fetch_nib",  32'(nibble),  32'd0);
        check("s1_fetch_busy", 32'(busy),    32'd1);
        check("s1_fetch_idx",  32'(idx),     32'd2);

        // Start while busy sets the sticky error flag.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
        check("err_set",      32'(error),   32'd1);
        check("err_busy",     32'(busy),    32'd1);
        check("err_fetch_le", 32'(load_en), 32'd0);

        // Feed 0x7A and stall its HI nibble for 3 cycles.
        in_valid = 1'b1; in_data = 8'h7A;
        next_cycle();
        in_valid = 1'b0;
        next_cycle(); #1;
        check("h_lo_nib", 32'(nibble), 32'hA);
        check("h_lo_idx", 32'(idx),    32'd2);
        next_cycle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #1;
            check($sformatf("h_held%0d_le", i),  32'(load_en), 32'd0);
            check($sformatf("h_held%0d_nib", i), 32'(nibble),  32'd0);
        end
        next_cycle();
        hold = 1'b0;
        #1;
        check("h_rep_le",  32'(load_en), 32'd1);
        check("h_rep_nib", 32'(nibble),  32'h7);
        check("h_rep_idx", 32'(idx),     32'd2);
        next_cycle(); #1;
        check("h_after_idx", 32'(idx),   32'd3);
        check("err_sticky",  32'(error), 32'd1);
        exp_csum = CSUM_EN ? (8'hA0 ^ 8'h41 ^ 8'h7A) : 8'h00;
        check("s1_csum", 32'(csum), 32'(exp_csum));

        // Buffer 3 bytes, park in LO with hold, then reset mid-LO.
        in_valid = 1'b1; in_data = 8'h11;
        next_cycle();
        in_data = 8'h22;
        next_cycle();
        in_data = 8'h33; hold = 1'b1;
        #1;
        check("pre_rst_le", 32'(load_en), 32'd0);
        next_cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("mid");
        next_cycle();
        reset = 1'b0; hold = 1'b0;
        #1;
        check_reset_values("post");
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
        check("flush_busy", 32'(busy),    32'd1);
        check("flush_le0",  32'(load_en), 32'd0);
        next_cycle(); #1;
        check("flush_le1",  32'(load_en), 32'd0);

        // Session 2: full 12-byte stream with the FIFO kept fed, then a 13th byte offered.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        nb = 0; le_cnt = 0; le_first = -1; le_last = -1;
        done_cnt = 0; done_cyc = -1; extra_accept = 0; cap_checked = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_valid = (nb <= 12);
            in_data  = (nb < 12) ? 8'(nb) : 8'hFF;
            start    = (c == 4);
            #1;
            if (load_en) begin
                check($sformatf("s2_nib%0d", le_cnt), 32'(nibble),
                      (le_cnt % 2 == 0) ? 32'((le_cnt / 2) & 4'hF) : 32'((le_cnt / 2) >> 4));
                if (le_first < 0) le_first = c;
                le_last = c;
                le_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (nb == 12 && busy && !cap_checked) begin
                check("s2_cap_ready", 32'(in_ready), 32'd0);
                cap_checked = 1'b1;
            end
            if (in_valid && in_ready) begin
                if (nb == 12) extra_accept++;
                else          nb++;
            end
            next_cycle();
        end
        start = 1'b0; in_valid = 1'b0;
        check("s2_le_cnt",     32'(le_cnt),                  32'd24);
        check("s2_le_consec",  32'(le_last - le_first + 1),  32'd24);
        check("s2_first_le",   32'(le_first),                32'd5);
        check("s2_done_cnt",   32'(done_cnt),                32'd1);
        check("s2_done_cyc",   32'(done_cyc),                32'(le_last + 1));
        check("s2_13th_taken", 32'(extra_accept),            32'd0);
        check("s2_cap_seen",   32'(cap_checked),             32'd1);
        #1;
        check("fin_ready", 32'(in_ready), 32'd0);
        check("fin_busy",  32'(busy),     32'd0);
        check("fin_idx",   32'(idx),      32'd11);
        check("fin_le",    32'(load_en),  32'd0);
        check("fin_err",   32'(error),    32'd0);
        exp_csum = 8'h00;
        if (CSUM_EN) for (int b = 0; b < 12; b++) exp_csum ^= 8'(b);
        check("fin_csum", 32'(csum), 32'(exp_csum));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
